// File: rtl/input_conditioner.sv
// input_conditioner: synchronizes and debounces the raw switch bus and the
// enter push-button, and produces a debounced enter level, a one-cycle
// enter pulse and a sticky enter-pending flag for the CPU IO path.
// Optional feature macro: SWITCH_LOCK_EN (freeze switch_stable while
// enter_pending is set).
module input_conditioner #(
  parameter int SW_WIDTH        = 16,
  parameter int DEBOUNCE_CYCLES = 20000
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [SW_WIDTH-1:0] switch_raw,
  input  logic                enter_raw,
  input  logic                enter_ack,
  output logic [SW_WIDTH-1:0] switch_stable,
  output logic                switch_changed,
  output logic                enter_level,
  output logic                enter_pulse,
  output logic                enter_pending
);

  localparam int              CW       = $clog2(DEBOUNCE_CYCLES) + 1;
  localparam logic [CW-1:0]   CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

  logic [SW_WIDTH-1:0] sw_s1, sw_s2, sw_prev;
  logic                en_s1, en_s2;
  logic [CW-1:0]       en_cnt, sw_cnt;
  logic                en_done, en_rise, sw_done, sw_lock;

  assign en_done = (en_cnt == CNT_LAST);
  assign sw_done = (sw_cnt == CNT_LAST);
  // Level is about to go 0->1 on this edge.
  assign en_rise = en_s2 && !enter_level && en_done;

`ifdef SWITCH_LOCK_EN
  assign sw_lock = enter_pending;
`else
  assign sw_lock = 1'b0;
`endif

  // Two-flop synchronizers for every asynchronous input.
  always_ff @(posedge clk) begin
    if (!rst) begin
      sw_s1 <= '0;
      sw_s2 <= '0;
      en_s1 <= 1'b0;
      en_s2 <= 1'b0;
    end else begin
      sw_s1 <= switch_raw;
      sw_s2 <= sw_s1;
      en_s1 <= enter_raw;
      en_s2 <= en_s1;
    end
  end

  // Enter debounce: any agreeing cycle restarts the disagreement count.
  always_ff @(posedge clk) begin
    if (!rst) begin
      enter_level <= 1'b0;
      en_cnt      <= '0;
    end else if (en_s2 == enter_level) begin
      en_cnt <= '0;
    end else if (en_done) begin
      enter_level <= en_s2;
      en_cnt      <= '0;
    end else begin
      en_cnt <= en_cnt + 1'b1;
    end
  end

  // Rising-edge pulse and sticky pending flag; a set beats a same-cycle ack.
  always_ff @(posedge clk) begin
    if (!rst) begin
      enter_pulse   <= 1'b0;
      enter_pending <= 1'b0;
    end else begin
      enter_pulse   <= en_rise;
      enter_pending <= en_rise | (enter_pending & ~enter_ack);
    end
  end

  // Switch debounce on the whole word; any change of sw_s2 restarts the count.
  always_ff @(posedge clk) begin
    if (!rst) begin
      switch_stable  <= '0;
      switch_changed <= 1'b0;
      sw_prev        <= '0;
      sw_cnt         <= '0;
    end else begin
      sw_prev        <= sw_s2;
      switch_changed <= 1'b0;
      if (sw_lock || (sw_s2 == switch_stable) || (sw_s2 != sw_prev)) begin
        sw_cnt <= '0;
      end else if (sw_done) begin
        switch_stable  <= sw_s2;
        switch_changed <= 1'b1;
        sw_cnt         <= '0;
      end else begin
        sw_cnt <= sw_cnt + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_input_conditioner.sv
// Self-checking bench for input_conditioner (DEBOUNCE_CYCLES=4).
module tb_input_conditioner;

  localparam int W = 16;
  localparam int D = 4;

  logic         clk = 1'b0;
  logic         rst;
  logic [W-1:0] switch_raw;
  logic         enter_raw;
  logic         enter_ack;
  logic [W-1:0] switch_stable;
  logic         switch_changed;
  logic         enter_level;
  logic         enter_pulse;
  logic         enter_pending;

  input_conditioner #(.SW_WIDTH(W), .DEBOUNCE_CYCLES(D)) dut (
    .clk           (clk),
    .rst           (rst),
    .switch_raw    (switch_raw),
    .enter_raw     (enter_raw),
    .enter_ack     (enter_ack),
    .switch_stable (switch_stable),
    .switch_changed(switch_changed),
    .enter_level   (enter_level),
    .enter_pulse   (enter_pulse),
    .enter_pending (enter_pending)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  // Reference model: debounce decided from a history of synchronized samples.
  bit           m_en_s1, m_en_s2, m_level, m_pulse, m_pending, m_changed;
  logic [W-1:0] m_sw_s1, m_sw_s2, m_stable;
  int           n = 0, last_en = 0, last_sw = 0;
  bit           en_hist [0:4095];
  logic [W-1:0] sw_hist [0:4095];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_edge();
    bit flip, upd, ok;
    n++;
    if (!rst) begin
      m_en_s1 = 0; m_en_s2 = 0; m_level = 0; m_pulse = 0; m_pending = 0;
      m_changed = 0; m_sw_s1 = '0; m_sw_s2 = '0; m_stable = '0;
      last_en = n; last_sw = n;
      en_hist[n] = 0; sw_hist[n] = '0;
    end else begin
      en_hist[n] = m_en_s2;
      sw_hist[n] = m_sw_s2;
      // Enter flips after D consecutive samples that disagree with it.
      flip = 0;
      if (n - last_en >= D) begin
        ok = 1;
        for (int j = n - D + 1; j <= n; j++) if (en_hist[j] == m_level) ok = 0;
        flip = ok;
      end
      // Switches update after D+1 identical samples differing from stable.
      upd = 0;
      if (n - last_sw >= D) begin
        ok = 1;
        for (int j = n - D; j <= n; j++)
          if (sw_hist[j] !== sw_hist[n] || sw_hist[j] === m_stable) ok = 0;
        upd = ok;
      end
`ifdef SWITCH_LOCK_EN
      if (m_pending) begin
        upd = 0;
        last_sw = n;
      end
`endif
      m_pulse   = flip && !m_level;
      m_pending = m_pulse || (m_pending && !enter_ack);
      if (flip) begin
        m_level = !m_level;
        last_en = n;
      end
      m_changed = upd;
      if (upd) begin
        m_stable = sw_hist[n];
        last_sw  = n;
      end
      m_en_s2 = m_en_s1; m_en_s1 = enter_raw;
      m_sw_s2 = m_sw_s1; m_sw_s1 = switch_raw;
    end
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
    chk("switch_stable",  switch_stable,  m_stable);
    chk("switch_changed", switch_changed, m_changed);
    chk("enter_level",    enter_level,    m_level);
    chk("enter_pulse",    enter_pulse,    m_pulse);
    chk("enter_pending",  enter_pending,  m_pending);
  endtask

  task automatic steps(input int k);
    for (int i = 0; i < k; i++) step();
  endtask

  int pulses, changes;
  bit saw_a5;

  initial begin
    rst = 1'b0; switch_raw = '1; enter_raw = 1'b1; enter_ack = 1'b0;

    // Reset held with raw inputs high: all outputs stay low.
    for (int i = 0; i < 5; i++) begin
      step();
      chk("rst_outputs", {switch_stable, switch_changed, enter_level, enter_pulse, enter_pending}, 0);
    end

    // Release: enter rises at edge 6, switches at edge 7.
    rst = 1'b1;
    for (int i = 1; i <= 5; i++) begin
      step();
      chk("enter_level_early", enter_level, 0);
    end
    step();
    chk("enter_level_edge6", enter_level, 1);
    chk("enter_pulse_edge6", enter_pulse, 1);
    chk("switch_stable_edge6", switch_stable, 16'h0000);
    step();
    chk("enter_pulse_once", enter_pulse, 0);
    chk("switch_stable_edge7", switch_stable, 16'hFFFF);
    chk("switch_changed_edge7", switch_changed, 1);
    steps(2);
    chk("pending_held", enter_pending, 1);
    enter_ack = 1'b1; step(); enter_ack = 1'b0;
    chk("pending_cleared", enter_pending, 0);
    enter_ack = 1'b1; step(); enter_ack = 1'b0;
    chk("ack_when_idle", enter_pending, 0);

    // Release enter: falling level produces no pulse.
    enter_raw = 1'b0;
    pulses = 0;
    for (int i = 0; i < 10; i++) begin step(); pulses += int'(enter_pulse); end
    chk("fall_no_pulse", pulses, 0);
    chk("fall_level", enter_level, 0);

    // Glitch rejection: 1,0,1,0 for two cycles each, then hold high.
    for (int b = 0; b < 4; b++) begin
      enter_raw = (b % 2 == 0);
      steps(2);
    end
    enter_raw = 1'b1;
    pulses = 0;
    for (int i = 1; i <= 12; i++) begin
      step();
      pulses += int'(enter_pulse);
      if (i == 5) chk("glitch_level_pre", enter_level, 0);
      if (i == 6) chk("glitch_pulse_at6", enter_pulse, 1);
    end
    chk("glitch_pulses", pulses, 1);

    // Switch word changing mid-count restarts the debounce.
    switch_raw = 16'h0000; steps(10);
    chk("sw_zero", switch_stable, 16'h0000);
    changes = 0; saw_a5 = 0;
    switch_raw = 16'h00A5;
    for (int i = 0; i < 3; i++) begin
      step(); changes += int'(switch_changed); saw_a5 |= (switch_stable == 16'h00A5);
    end
    switch_raw = 16'h00A4;
    for (int i = 0; i < 12; i++) begin
      step(); changes += int'(switch_changed); saw_a5 |= (switch_stable == 16'h00A5);
    end
    chk("sw_never_a5", saw_a5, 0);
    chk("sw_changed_count", changes, 1);
    chk("sw_final_a4", switch_stable, 16'h00A4);

    // Ack coinciding with a new rising pulse: set wins.
    enter_raw = 1'b0; steps(10);
    enter_raw = 1'b1; steps(5);
    enter_ack = 1'b1; step(); enter_ack = 1'b0;
    chk("coinc_pulse", enter_pulse, 1);
    chk("coinc_pending", enter_pending, 1);
    enter_ack = 1'b1; step(); enter_ack = 1'b0;
    chk("coinc_cleared", enter_pending, 0);

    // Switch change while enter is pending.
    enter_raw = 1'b0; steps(10);
    enter_raw = 1'b1; steps(8);
    chk("lock_pending", enter_pending, 1);
    switch_raw = 16'hFFFF; steps(12);
`ifdef SWITCH_LOCK_EN
    chk("lock_frozen", switch_stable, 16'h00A4);
    enter_ack = 1'b1; step(); enter_ack = 1'b0;
    steps(D - 1);
    chk("lock_still_old", switch_stable, 16'h00A4);
    step();
    chk("lock_released", switch_stable, 16'hFFFF);
`else
    chk("nolock_follow", switch_stable, 16'hFFFF);
    enter_ack = 1'b1; step(); enter_ack = 1'b0;
`endif

    // Reset mid-count discards the partial debounce.
    enter_raw = 1'b0; steps(10);
    enter_raw = 1'b1; steps(4);
    rst = 1'b0; step();
    chk("midrst_level", enter_level, 0);
    chk("midrst_stable", switch_stable, 0);
    rst = 1'b1;
    pulses = 0;
    for (int i = 0; i < 5; i++) begin step(); pulses += int'(enter_pulse); end
    chk("midrst_no_pulse", pulses, 0);
    steps(4);

    // Randomized traffic against the model.
    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(0, 5) == 0) enter_raw = ~enter_raw;
      if ($urandom_range(0, 9) == 0) switch_raw = W'($urandom);
      enter_ack = ($urandom_range(0, 7) == 0);
      rst = ($urandom_range(0, 149) != 0);
      step();
    end
    rst = 1'b1; enter_ack = 1'b0;
    steps(12);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/input_conditioner.md
# input_conditioner

Input conditioning stage placed directly upstream of the CPU top. It takes the raw board switch bus and the raw confirm ("enter") push-button, then synchronizes and debounces them. It presents clean signals to the CPU's IO path:
- a stable switch bus;
- a debounced enter level;
- a one-cycle enter pulse;
- a sticky enter-pending flag that the CPU acknowledges once it has consumed the input.

The block runs on the divided CPU clock.

## Interface
Parameters:
- `SW_WIDTH`, default 16: width of the switch bus.
- `DEBOUNCE_CYCLES`, default 20000: number of consecutive disagreeing cycles required before a stable output changes. Legal range is ≥1.

Ports:
- `clk`  in  1  divided CPU clock; all logic is on the rising edge.
- `rst`  in  1  reset, synchronous, active-low.
- `switch_raw`  in  `SW_WIDTH`  raw switch pins, asynchronous.
- `enter_raw`  in  1  raw enter button, asynchronous, active-high.
- `enter_ack`  in  1  CPU has consumed the pending enter; one-cycle strobe.
- `switch_stable`  out  `SW_WIDTH`  debounced switch bus.
- `switch_changed`  out  1  one-cycle pulse when `switch_stable` updates.
- `enter_level`  out  1  debounced enter level.
- `enter_pulse`  out  1  one-cycle pulse on the debounced 0→1 transition of enter.
- `enter_pending`  out  1  sticky flag, set by `enter_pulse` and cleared by `enter_ack`.

## Operation
- Synchronizers: every raw input passes through a 2-flop synchronizer (`sw_s2`, `en_s2`) before use. Both stages reset to 0.
- Enter debounce:
  - Counter `en_cnt`, width `$clog2(DEBOUNCE_CYCLES)+1`.
  - If `en_s2 == enter_level`, then `en_cnt <= 0`.
  - Else if `en_cnt == DEBOUNCE_CYCLES-1`, then `enter_level <= en_s2` and `en_cnt <= 0`.
  - Else `en_cnt` increments.
  - A single agreeing cycle restarts the count, so glitches shorter than `DEBOUNCE_CYCLES` are rejected.
- Switch debounce: the switch bus is treated as one word, with counter `sw_cnt` and a register `sw_prev` holding the last `sw_s2` value.
  - If `sw_s2 == switch_stable`, or `sw_s2 != sw_prev`, then `sw_cnt <= 0` (a further change restarts the count).
  - Else if `sw_cnt == DEBOUNCE_CYCLES-1`, then `switch_stable <= sw_s2`, `switch_changed <= 1`, and `sw_cnt <= 0`.
  - Else `sw_cnt` increments.
- `enter_pulse` is asserted for exactly the one cycle after `enter_level` goes 0→1. The 1→0 transition produces no pulse.
- `enter_pending`:
  - Set on `enter_pulse`, cleared on `enter_ack`.
  - If `enter_pulse` and `enter_ack` occur in the same cycle, the set wins and the flag stays 1.
  - `enter_ack` while the flag is 0 has no effect.
- Counters saturate only through the compare; they never wrap.

## Timing
- Reset values: every output is 0. `en_cnt`, `sw_cnt` and `sw_prev` are also 0.
- Reset applied mid-count discards any partial debounce; no pulse is emitted.
- Enter latency:
  - A raw change that is held steady and first captured by `en_s1` at edge 1 produces `enter_level` toggling at edge `2+DEBOUNCE_CYCLES`.
  - `enter_pulse` is high during the following cycle.
  - `enter_pending` rises together with `enter_pulse`.
  - Example: `DEBOUNCE_CYCLES=1` gives `enter_level` at edge 3.
- Switch latency is one cycle longer than enter latency, because of the `sw_prev` compare: `switch_stable` updates at edge `3+DEBOUNCE_CYCLES`. `switch_changed` is high in the same cycle that the new value appears.
- Outputs are registered; there are no combinational paths from input to output.

## Configuration
- `SWITCH_LOCK_EN`, when defined:
  - `switch_stable` is frozen while `enter_pending == 1`.
  - `sw_cnt` holds at 0 during the freeze, and `switch_changed` is suppressed.
  - Debouncing resumes in the cycle after `enter_pending` clears. The CPU therefore reads the switch value that was present at confirmation.
- When not defined, the switch path is independent of the enter path.

## Test plan
1. Reset: drive `rst=0` with raw inputs at 1 for 5 cycles. Required: all outputs stay 0. Release reset: outputs stay 0 until the debounce completes.
2. `DEBOUNCE_CYCLES=4`, enter held at 1 from edge 1. Required: `enter_level`=1 at edge 6; `enter_pulse`=1 for exactly one cycle; `enter_pending`=1 until `enter_ack`, then 0 on the next edge.
3. Glitch rejection, `DEBOUNCE_CYCLES=4`: enter bounces 1,0,1,0 every 2 cycles, then holds 1. Required: a single `enter_pulse`, occurring 4 cycles after the last bounce has passed the synchronizer.
4. Switches step from 0x0000 to 0x00A5 to 0x00A4 mid-count, then hold. Required: `switch_stable` never shows 0x00A5 and goes straight to 0x00A4, with one `switch_changed` pulse.
5. `enter_ack` and a new `enter_pulse` in the same cycle. Required: `enter_pending` remains 1.
6. `SWITCH_LOCK_EN` defined: with `enter_pending`=1, change the switches to 0xFFFF. Required: `switch_stable` holds its old value. After `enter_ack`, 0xFFFF appears `DEBOUNCE_CYCLES`+1 cycles later.
